temporizador_regressivo: RTL and testbench
==========================================

// Module: temporizador_regressivo
// PURPOSE
//   Loadable down-counting timer: complement of the modulo-M up-counter.
//   Counts from a programmable load value L down to 0 under FSM control
//   (idle / counting / paused / expired), with pause, retrigger and a
//   one-cycle expiry pulse. Used by game/serial control units for timeouts.
// PARAMETERS
//   M  3000  default load is M-1, so a count lasts M cycles; M-1 < 2**N
//   N  12    width of Q, valor and internal load register L
// PORTS
//   clock    in   1  single clock, all logic on rising edge
//   reset    in   1  synchronous, active-high reset
//   carrega  in   1  load: L <= valor, Q <= valor, go to PARADO
//   valor    in   N  load value, 0..2**N-1, no modulus applied
//   inicia   in   1  start, or restart from L
//   pausa    in   1  level: hold count while high
//   Q        out  N  current count (registered)
//   fim      out  1  registered one-cycle pulse on expiry
//   meio     out  1  Q == L>>1 while in CONTANDO (combinational)
//   ativo    out  1  state is CONTANDO or PAUSADO
//   zerado   out  1  state is ESGOTADO (level)
// BEHAVIOUR
//   - Reset: state PARADO, L=M-1, Q=M-1, fim=0, meio=0, ativo=0, zerado=0.
//   - Priority each cycle: reset > carrega > inicia > pausa.
//   - carrega, any state: L<=valor, Q<=valor, state<=PARADO, fim<=0.
//   - PARADO: Q holds. inicia -> CONTANDO, Q<=L; no decrement that cycle.
//   - CONTANDO, pausa=0: Q!=0 -> Q<=Q-1; Q==0 -> state<=ESGOTADO, fim<=1.
//     Counting lasts L+1 cycles in CONTANDO; fim high in the cycle after
//     the cycle with Q==0.
//   - CONTANDO, pausa=1: -> PAUSADO, Q not decremented that cycle.
//   - CONTANDO, inicia=1 (retrigger): Q<=L, stay CONTANDO.
//   - PAUSADO: Q holds. pausa=0 -> CONTANDO, first decrement next cycle.
//     inicia ignored while paused.
//   - ESGOTADO: Q=0, zerado=1. inicia -> CONTANDO with Q<=L.
//     Otherwise stay.
//   - fim is high for exactly one cycle per expiry. It is 0 in every
//     other cycle, including the cycle after carrega or reset.
//   - meio: L>>1 uses floor. It is 0 outside CONTANDO, including in
//     PAUSADO, even when Q matches.
//   - L=0: after inicia, one CONTANDO cycle with Q=0 and meio=1
//     (0>>1 = 0), then expiry.
//   - Q never wraps: there is no decrement below 0 and no increment path.
//   - Unused state encodings recover to PARADO with Q unchanged.
// TESTING
//   1 reset with M=3000, N=12 -> Q=2999; fim, meio, ativo, zerado all 0.
//   2 M=10, N=4: pulse inicia -> next cycle ativo=1, Q=9; Q steps 9..0
//     over 10 cycles. Next cycle: fim=1 for 1 cycle, zerado=1, ativo=0,
//     Q stays 0.
//   3 same run -> meio=1 only in the single cycle where Q=4.
//   4 hold pausa high 3 cycles once Q=6 -> Q=6 for 3 cycles, ativo=1,
//     meio=0; after release Q=5 on the following cycle.
//   5 carrega with valor=3 mid-count -> Q=3, PARADO, ativo=0; inicia ->
//     Q 3,2,1,0 then fim. carrega with valor=0, inicia -> fim 2 cycles
//     after the inicia cycle.
//   6 inicia at Q=2 -> Q=9, stays CONTANDO. reset at Q=5 -> Q=9, PARADO,
//     fim=0, and no expiry follows.

Source files
------------

// File: rtl/temporizador_regressivo_if.sv
// Control/status bundle for the down-counting timer: commands flow master -> slave,
// count and status flags flow back.
interface temporizador_regressivo_if #(
    parameter int N = 12
);
    logic         carrega;
    logic [N-1:0] valor;
    logic         inicia;
    logic         pausa;
    logic [N-1:0] Q;
    logic         fim;
    logic         meio;
    logic         ativo;
    logic         zerado;

    modport master (
        output carrega, valor, inicia, pausa,
        input  Q, fim, meio, ativo, zerado
    );

    modport slave (
        input  carrega, valor, inicia, pausa,
        output Q, fim, meio, ativo, zerado
    );
endinterface

// File: rtl/temporizador_regressivo.sv
// Loadable down-counting timer with idle/counting/paused/expired control,
// retrigger, level pause and a registered one-cycle expiry pulse.
module temporizador_regressivo #(
    parameter int M = 3000,   // M-1 must fit in N bits
    parameter int N = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    temporizador_regressivo_if.slave bus
);
    localparam logic [N-1:0] LOAD_DEFAULT = N'(M - 1);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        ESGOTADO = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [N-1:0] r_l;
    logic [N-1:0] w_l_next;
    logic [N-1:0] r_q;
    logic [N-1:0] w_q_next;
    logic         r_fim;
    logic         w_fim_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= PARADO;
            r_l     <= LOAD_DEFAULT;
            r_q     <= LOAD_DEFAULT;
            r_fim   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_l     <= w_l_next;
            r_q     <= w_q_next;
            r_fim   <= w_fim_next;
        end
    end

    // Load beats start beats pause; fim is a pulse, so it defaults low every cycle.
    always_comb begin
        w_state_next = r_state;
        w_l_next     = r_l;
        w_q_next     = r_q;
        w_fim_next   = 1'b0;
        if (bus.carrega) begin
            w_l_next     = bus.valor;
            w_q_next     = bus.valor;
            w_state_next = PARADO;
        end else begin
            case (r_state)
                PARADO: begin
                    if (bus.inicia) begin
                        w_state_next = CONTANDO;
                        w_q_next     = r_l;
                    end
                end
                CONTANDO: begin
                    if (bus.inicia) begin
                        w_q_next = r_l;
                    end else if (bus.pausa) begin
                        w_state_next = PAUSADO;
                    end else if (r_q == '0) begin
                        w_state_next = ESGOTADO;
                        w_fim_next   = 1'b1;
                    end else begin
                        w_q_next = r_q - 1'b1;
                    end
                end
                PAUSADO: begin
                    if (!bus.pausa) begin
                        w_state_next = CONTANDO;
                    end
                end
                ESGOTADO: begin
                    if (bus.inicia) begin
                        w_state_next = CONTANDO;
                        w_q_next     = r_l;
                    end
                end
                default: begin
                    w_state_next = PARADO;
                end
            endcase
        end
    end

    assign bus.Q      = r_q;
    assign bus.fim    = r_fim;
    assign bus.meio   = (r_state == CONTANDO) && (r_q == (r_l >> 1));
    assign bus.ativo  = (r_state == CONTANDO) || (r_state == PAUSADO);
    assign bus.zerado = (r_state == ESGOTADO);
endmodule

// File: tb/tb_temporizador_regressivo.sv
// Bench for the down-counting timer: a rule-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_temporizador_regressivo;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    bit   chk_en;

    temporizador_regressivo_if #(.N(4))  sif ();
    temporizador_regressivo_if #(.N(12)) bif ();

    temporizador_regressivo #(.M(10), .N(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (sif)
    );

    temporizador_regressivo dut_big (
        .clock (clk),
        .reset (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 held, 3 expired.
    int m_mode;
    int m_l;
    int m_q;
    int m_fim;

    always @(posedge clk) begin
        m_fim = 0;
        if (rst) begin
            m_mode = 0;
            m_l    = 9;
            m_q    = 9;
        end else if (sif.carrega) begin
            m_l    = int'(sif.valor);
            m_q    = m_l;
            m_mode = 0;
        end else if (sif.inicia && m_mode != 2) begin
            m_mode = 1;
            m_q    = m_l;
        end else if (m_mode == 1 && sif.pausa) begin
            m_mode = 2;
        end else if (m_mode == 2 && !sif.pausa) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_q > 0) m_q = m_q - 1;
            else begin
                m_mode = 3;
                m_fim  = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_Q",      int'(sif.Q),      m_q);
            chk("cyc_fim",    int'(sif.fim),    m_fim);
            chk("cyc_meio",   int'(sif.meio),   int'(m_mode == 1 && m_q == m_l / 2));
            chk("cyc_ativo",  int'(sif.ativo),  int'(m_mode == 1 || m_mode == 2));
            chk("cyc_zerado", int'(sif.zerado), int'(m_mode == 3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_inicia();
        sif.inicia = 1'b1;
        tick();
        sif.inicia = 1'b0;
    endtask

    task automatic load(input int v);
        sif.carrega = 1'b1;
        sif.valor   = 4'(v);
        tick();
        sif.carrega = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        sif.carrega = 1'b0; sif.valor = '0; sif.inicia = 1'b0; sif.pausa = 1'b0;
        bif.carrega = 1'b0; bif.valor = '0; bif.inicia = 1'b0; bif.pausa = 1'b0;
        ticks(2);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state, default and small instance
        chk("rst_big_Q",      int'(bif.Q), 2999);
        chk("rst_big_flags",  int'({bif.fim, bif.meio, bif.ativo, bif.zerado}), 0);
        chk("rst_small_Q",    int'(sif.Q), 9);
        chk("rst_small_flags", int'({sif.fim, sif.meio, sif.ativo, sif.zerado}), 0);
        tick();
        chk("idle_big_Q", int'(bif.Q), 2999);
        chk("idle_Q", int'(sif.Q), 9);

        // Full count 9..0 with meio only at Q=4
        pulse_inicia();
        for (int k = 0; k < 10; k++) begin
            $display("count step %0d: Q=%0d meio=%0d ativo=%0d", k, sif.Q, sif.meio, sif.ativo);
            chk("run_Q", int'(sif.Q), 9 - k);
            chk("run_meio", int'(sif.meio), int'(k == 5));
            chk("run_ativo", int'(sif.ativo), 1);
            chk("run_fim", int'(sif.fim), 0);
            tick();
        end
        chk("exp_fim", int'(sif.fim), 1);
        chk("exp_zerado", int'(sif.zerado), 1);
        chk("exp_ativo", int'(sif.ativo), 0);
        chk("exp_Q", int'(sif.Q), 0);
        tick();
        chk("exp_fim_pulse", int'(sif.fim), 0);
        chk("exp_zerado_hold", int'(sif.zerado), 1);
        chk("exp_Q_hold", int'(sif.Q), 0);

        // Pause at Q=6 for 3 cycles
        pulse_inicia();
        chk("restart_Q", int'(sif.Q), 9);
        ticks(3);
        chk("pre_pause_Q", int'(sif.Q), 6);
        sif.pausa = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            $display("pause step %0d: Q=%0d ativo=%0d meio=%0d", k, sif.Q, sif.ativo, sif.meio);
            chk("pause_Q", int'(sif.Q), 6);
            chk("pause_ativo", int'(sif.ativo), 1);
            chk("pause_meio", int'(sif.meio), 0);
        end
        sif.inicia = 1'b1;   // ignored while paused
        tick();
        sif.inicia = 1'b0;
        chk("pause_inicia_ignored", int'(sif.Q), 6);
        sif.pausa = 1'b0;
        tick();
        chk("resume_Q_held", int'(sif.Q), 6);
        tick();
        chk("resume_Q_dec", int'(sif.Q), 5);

        // Load 3 mid-count, then count 3..0 and expire
        load(3);
        chk("load3_Q", int'(sif.Q), 3);
        chk("load3_ativo", int'(sif.ativo), 0);
        chk("load3_fim", int'(sif.fim), 0);
        pulse_inicia();
        for (int k = 0; k < 4; k++) begin
            chk("l3_Q", int'(sif.Q), 3 - k);
            chk("l3_meio", int'(sif.meio), int'(k == 2));
            tick();
        end
        chk("l3_fim", int'(sif.fim), 1);

        // L = 0: single counting cycle with meio, fim 2 cycles after inicia
        load(0);
        pulse_inicia();
        chk("l0_Q", int'(sif.Q), 0);
        chk("l0_meio", int'(sif.meio), 1);
        chk("l0_fim_early", int'(sif.fim), 0);
        tick();
        chk("l0_fim", int'(sif.fim), 1);
        tick();
        chk("l0_fim_once", int'(sif.fim), 0);

        // Retrigger at Q=2, then reset at Q=5 with no expiry afterwards
        load(9);
        pulse_inicia();
        ticks(7);
        chk("pre_retrig_Q", int'(sif.Q), 2);
        pulse_inicia();
        chk("retrig_Q", int'(sif.Q), 9);
        chk("retrig_ativo", int'(sif.ativo), 1);
        ticks(4);
        chk("pre_reset_Q", int'(sif.Q), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset_Q", int'(sif.Q), 9);
        chk("mid_reset_ativo", int'(sif.ativo), 0);
        chk("mid_reset_fim", int'(sif.fim), 0);
        for (int k = 0; k < 14; k++) begin
            tick();
            chk("no_expiry_fim", int'(sif.fim), 0);
        end

        // Simultaneous commands: inicia beats pausa, carrega beats inicia
        pulse_inicia();
        tick();
        sif.inicia = 1'b1;
        sif.pausa  = 1'b1;
        tick();
        chk("inicia_over_pausa_Q", int'(sif.Q), 9);
        chk("inicia_over_pausa_ativo", int'(sif.ativo), 1);
        sif.pausa   = 1'b0;
        sif.carrega = 1'b1;
        sif.valor   = 4'd7;
        tick();
        sif.carrega = 1'b0;
        sif.inicia  = 1'b0;
        chk("carrega_over_inicia_Q", int'(sif.Q), 7);
        chk("carrega_over_inicia_ativo", int'(sif.ativo), 0);
        // Load 15 (full width, no modulus) and let it run out
        load(15);
        pulse_inicia();
        ticks(18);

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
